// File: rtl/pwb_pkg.sv
// Shared types for the peripheral posted-write buffer: drain FSM encoding and
// queue-entry sizing.
package pwb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_ISSUE = 3'd1,
    ST_W_WAIT  = 3'd2,
    ST_R_ISSUE = 3'd3,
    ST_R_WAIT  = 3'd4
  } pwb_state_e;

  // A queue entry packs {addr, data}, address in the upper bits.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/pwb_fifo.sv
// Circular FIFO holding posted writes; head is the oldest entry, count is
// registered so full/empty carry no combinational path from push/pop.
module pwb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  // A push into a full queue is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/periph_write_buffer.sv
// Posted-write buffer: stores are acked once queued; reads wait for the queue
// to drain so AXI sees the same order the CPU issued.
module periph_write_buffer
  import pwb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] U_Addr,
  input  logic [DATA_WIDTH-1:0] U_WriteData,
  input  logic                  U_StartWrite,
  input  logic                  U_StartRead,
  output logic                  U_WriteCompleted,
  output logic                  U_ReadCompleted,
  output logic [DATA_WIDTH-1:0] U_ReadData,
  output logic [ADDR_WIDTH-1:0] D_Addr,
  output logic [DATA_WIDTH-1:0] D_WriteData,
  output logic                  D_StartWrite,
  output logic                  D_StartRead,
  input  logic                  D_WriteCompleted,
  input  logic                  D_ReadCompleted,
  input  logic [DATA_WIDTH-1:0] D_ReadData,
  output logic                  Full,
  output logic                  Empty
);
  localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  pwb_state_e            state_q, state_d;
  logic                  pend_wr_vld, pend_rd_vld, up_free;
  logic [ADDR_WIDTH-1:0] pend_wr_addr, pend_rd_addr;
  logic [DATA_WIDTH-1:0] pend_wr_data;
  logic                  push, pop, rd_done, fifo_full, fifo_empty, has_entry;
  logic [EW-1:0]         head;
  logic [CW-1:0]         fifo_count;

  assign up_free   = !pend_wr_vld && !pend_rd_vld;
  assign pop       = (state_q == ST_W_WAIT) && D_WriteCompleted;
  assign rd_done   = (state_q == ST_R_WAIT) && D_ReadCompleted;
  assign push      = pend_wr_vld && (!fifo_full || pop);
  assign has_entry = (fifo_count != '0);

  pwb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .push  (push),
    .wdata ({pend_wr_addr, pend_wr_data}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Full  = fifo_full;
  assign Empty = fifo_empty;

  // One request at a time upstream; a write strobe wins over a coincident read.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend_wr_vld  <= 1'b0;
      pend_rd_vld  <= 1'b0;
      pend_wr_addr <= '0;
      pend_wr_data <= '0;
      pend_rd_addr <= '0;
    end else begin
      if (up_free && U_StartWrite) begin
        pend_wr_vld  <= 1'b1;
        pend_wr_addr <= U_Addr;
        pend_wr_data <= U_WriteData;
      end else if (push) begin
        pend_wr_vld  <= 1'b0;
      end
      if (up_free && U_StartRead && !U_StartWrite) begin
        pend_rd_vld  <= 1'b1;
        pend_rd_addr <= U_Addr;
      end else if (rd_done) begin
        pend_rd_vld  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (has_entry)        state_d = ST_W_ISSUE;
        else if (pend_rd_vld) state_d = ST_R_ISSUE;
      end
      ST_W_ISSUE: state_d = ST_W_WAIT;
      ST_W_WAIT:  if (D_WriteCompleted) state_d = ST_IDLE;
      ST_R_ISSUE: state_d = ST_R_WAIT;
      ST_R_WAIT:  if (D_ReadCompleted) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign D_StartWrite = (state_q == ST_W_ISSUE);
  assign D_StartRead  = (state_q == ST_R_ISSUE);

  // Downstream address/data are loaded on leaving IDLE and held through WAIT.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q          <= ST_IDLE;
      D_Addr           <= '0;
      D_WriteData      <= '0;
      U_WriteCompleted <= 1'b0;
      U_ReadCompleted  <= 1'b0;
      U_ReadData       <= '0;
    end else begin
      state_q          <= state_d;
      U_WriteCompleted <= push;
      U_ReadCompleted  <= rd_done;
      if (rd_done) U_ReadData <= D_ReadData;
      if (state_q == ST_IDLE) begin
        if (has_entry)        {D_Addr, D_WriteData} <= head;
        else if (pend_rd_vld) D_Addr <= pend_rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_periph_write_buffer.sv
// Scoreboard bench for periph_write_buffer: expected downstream traffic and read
// data are queued at stimulus time and checked when the DUT emits them.
module tb_periph_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [AW-1:0] U_Addr = '0;
  logic [DW-1:0] U_WriteData = '0;
  logic          U_StartWrite = 1'b0, U_StartRead = 1'b0;
  logic          U_WriteCompleted, U_ReadCompleted;
  logic [DW-1:0] U_ReadData;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D_WriteData;
  logic          D_StartWrite, D_StartRead;
  logic          D_WriteCompleted = 1'b0, D_ReadCompleted = 1'b0;
  logic [DW-1:0] D_ReadData = '0;
  logic          Full, Empty;

  periph_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .U_Addr(U_Addr), .U_WriteData(U_WriteData),
    .U_StartWrite(U_StartWrite), .U_StartRead(U_StartRead),
    .U_WriteCompleted(U_WriteCompleted), .U_ReadCompleted(U_ReadCompleted),
    .U_ReadData(U_ReadData),
    .D_Addr(D_Addr), .D_WriteData(D_WriteData),
    .D_StartWrite(D_StartWrite), .D_StartRead(D_StartRead),
    .D_WriteCompleted(D_WriteCompleted), .D_ReadCompleted(D_ReadCompleted),
    .D_ReadData(D_ReadData),
    .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int dsw_cnt = 0, dsr_cnt = 0, uwc_cnt = 0, urc_cnt = 0;
  int last_dsw = 0, last_dsr = 0, last_uwc = 0, last_urc = 0;

  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [DW-1:0]    exp_rdata_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Passive monitor, sampling 1 time unit after each rising edge.
  always @(posedge Clk) begin
    #1;
    if (D_StartWrite) begin
      dsw_cnt++; last_dsw = cyc;
      if (exp_wr_q.size() == 0) chk("dsw_unexpected", 64'(D_StartWrite), 64'd0);
      else chk("dsw_addr_data", {D_Addr, D_WriteData}, exp_wr_q.pop_front());
    end
    if (D_StartRead) begin
      dsr_cnt++; last_dsr = cyc;
      if (exp_rd_q.size() == 0) chk("dsr_unexpected", 64'(D_StartRead), 64'd0);
      else chk("dsr_addr", 64'(D_Addr), 64'(exp_rd_q.pop_front()));
    end
    if (U_WriteCompleted) begin
      uwc_cnt++; last_uwc = cyc;
    end
    if (U_ReadCompleted) begin
      urc_cnt++; last_urc = cyc;
      if (exp_rdata_q.size() == 0) chk("urc_unexpected", 64'(U_ReadCompleted), 64'd0);
      else chk("urc_rdata", 64'(U_ReadData), 64'(exp_rdata_q.pop_front()));
    end
  end

  function automatic int get_cnt(input int w);
    case (w)
      0: return dsw_cnt;
      1: return dsr_cnt;
      2: return uwc_cnt;
      default: return urc_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int w, input int target);
    int n = 0;
    while (get_cnt(w) < target && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (get_cnt(w) < target) chk({"timeout_", tag}, 64'(get_cnt(w)), 64'(target));
  endtask

  task automatic up_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
    @(negedge Clk);
    U_Addr = a; U_WriteData = d; U_StartWrite = 1'b1; t = cyc;
    exp_wr_q.push_back({a, d});
    @(negedge Clk);
    U_StartWrite = 1'b0;
  endtask

  task automatic up_read(input logic [AW-1:0] a, output int t);
    @(negedge Clk);
    U_Addr = a; U_StartRead = 1'b1; t = cyc;
    exp_rd_q.push_back(a);
    @(negedge Clk);
    U_StartRead = 1'b0;
  endtask

  task automatic ds_wr_done(input int lat, output int t);
    repeat (lat) @(negedge Clk);
    D_WriteCompleted = 1'b1; t = cyc;
    @(negedge Clk);
    D_WriteCompleted = 1'b0;
  endtask

  task automatic ds_rd_done(input int lat, input logic [DW-1:0] d, output int t);
    repeat (lat) @(negedge Clk);
    D_ReadCompleted = 1'b1; D_ReadData = d; t = cyc;
    @(negedge Clk);
    D_ReadCompleted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t, tc, r, b_uwc, b_dsw, b_dsr, b_urc;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_full", 64'(Full), 64'd0);
    chk("rst_dstart", {D_StartWrite, D_StartRead, U_WriteCompleted, U_ReadCompleted}, 64'd0);
    chk("rst_daddr", {D_Addr, D_WriteData}, 64'd0);
    chk("rst_rdata", 64'(U_ReadData), 64'd0);
    Rst = 1'b1;

    // Single posted write
    repeat (2) @(negedge Clk);
    up_write(32'h4000_0010, 32'hDEAD_BEEF, t);
    wait_cnt("t1_ack", 2, 1);
    chk("t1_ack_lat", 64'(last_uwc - t), 64'd2);
    wait_cnt("t1_dsw", 0, 1);
    chk("t1_dsw_lat", 64'(last_dsw - t), 64'd3);
    chk("t1_empty_busy", 64'(Empty), 64'd0);
    ds_wr_done(3, tc);
    chk("t1_empty_after", 64'(Empty), 64'd1);
    repeat (5) @(negedge Clk);
    chk("t1_dsw_once", 64'(dsw_cnt), 64'd1);

    // Fill the queue with downstream held off
    b_uwc = uwc_cnt; b_dsw = dsw_cnt;
    for (int i = 0; i < 4; i++) begin
      up_write(32'h4000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), t);
      wait_cnt("t2_ack", 2, b_uwc + i + 1);
    end
    chk("t2_full", 64'(Full), 64'd1);
    chk("t2_one_started", 64'(dsw_cnt), 64'(b_dsw + 1));
    up_write(32'h4000_1010, 32'hA000_0004, t);
    repeat (6) @(negedge Clk);
    chk("t2_fifth_held", 64'(uwc_cnt), 64'(b_uwc + 4));
    ds_wr_done(0, tc);
    wait_cnt("t2_fifth_ack", 2, b_uwc + 5);
    chk("t2_fifth_ack_lat", 64'(last_uwc - tc), 64'd1);
    for (int k = 0; k < 4; k++) begin
      wait_cnt("t2_drain", 0, b_dsw + 2 + k);
      ds_wr_done(1, tc);
    end
    repeat (2) @(negedge Clk);
    chk("t2_drained", 64'(Empty), 64'd1);

    // Read behind two queued writes waits for both completions
    b_uwc = uwc_cnt; b_dsw = dsw_cnt; b_dsr = dsr_cnt; b_urc = urc_cnt;
    up_write(32'h4000_0000, 32'h1111_1111, t);
    wait_cnt("t3_ack1", 2, b_uwc + 1);
    up_write(32'h4000_0000, 32'h2222_2222, t);
    wait_cnt("t3_ack2", 2, b_uwc + 2);
    up_read(32'h4000_0004, t);
    exp_rdata_q.push_back(32'h1234_5678);
    wait_cnt("t3_dsw1", 0, b_dsw + 1);
    ds_wr_done(2, tc);
    wait_cnt("t3_dsw2", 0, b_dsw + 2);
    chk("t3_rd_held", 64'(dsr_cnt), 64'(b_dsr));
    ds_wr_done(2, tc);
    wait_cnt("t3_dsr", 1, b_dsr + 1);
    chk("t3_dsr_after_drain", 64'(last_dsr - tc), 64'd2);
    ds_rd_done(1, 32'h1234_5678, r);
    wait_cnt("t3_urc", 3, b_urc + 1);
    chk("t3_urc_lat", 64'(last_urc - r), 64'd1);

    // Read on an idle, empty buffer
    b_dsr = dsr_cnt; b_urc = urc_cnt; b_uwc = uwc_cnt;
    up_read(32'h4000_0020, t);
    exp_rdata_q.push_back(32'hCAFE_F00D);
    wait_cnt("t4_dsr", 1, b_dsr + 1);
    chk("t4_dsr_lat", 64'(last_dsr - t), 64'd2);
    ds_rd_done(2, 32'hCAFE_F00D, r);
    wait_cnt("t4_urc", 3, b_urc + 1);
    chk("t4_urc_lat", 64'(last_urc - r), 64'd1);
    // Stray completions while idle must not disturb anything
    @(negedge Clk);
    D_WriteCompleted = 1'b1; D_ReadCompleted = 1'b1; D_ReadData = 32'h0BAD_0BAD;
    @(negedge Clk);
    D_WriteCompleted = 1'b0; D_ReadCompleted = 1'b0;
    repeat (4) @(negedge Clk);
    chk("t4_rdata_hold", 64'(U_ReadData), 64'hCAFE_F00D);
    chk("t4_stray_urc", 64'(urc_cnt), 64'(b_urc + 1));
    chk("t4_stray_uwc", 64'(uwc_cnt), 64'(b_uwc));
    chk("t4_stray_empty", 64'(Empty), 64'd1);

    // Simultaneous write and read strobes: write wins, read dropped
    b_uwc = uwc_cnt; b_dsw = dsw_cnt; b_dsr = dsr_cnt; b_urc = urc_cnt;
    @(negedge Clk);
    U_Addr = 32'h4000_0030; U_WriteData = 32'h55AA_55AA;
    U_StartWrite = 1'b1; U_StartRead = 1'b1; t = cyc;
    exp_wr_q.push_back({32'h4000_0030, 32'h55AA_55AA});
    @(negedge Clk);
    U_StartWrite = 1'b0; U_StartRead = 1'b0;
    wait_cnt("t5_ack", 2, b_uwc + 1);
    chk("t5_ack_lat", 64'(last_uwc - t), 64'd2);
    wait_cnt("t5_dsw", 0, b_dsw + 1);
    ds_wr_done(1, tc);
    repeat (10) @(negedge Clk);
    chk("t5_no_dsr", 64'(dsr_cnt), 64'(b_dsr));
    chk("t5_no_urc", 64'(urc_cnt), 64'(b_urc));

    // Reset in W_WAIT with three entries queued
    b_uwc = uwc_cnt; b_dsw = dsw_cnt;
    for (int i = 0; i < 3; i++) begin
      up_write(32'h4000_2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), t);
      wait_cnt("t6_ack", 2, b_uwc + i + 1);
    end
    wait_cnt("t6_dsw", 0, b_dsw + 1);
    @(negedge Clk);
    Rst = 1'b0;
    exp_wr_q.delete();
    repeat (2) @(negedge Clk);
    chk("t6_empty", 64'(Empty), 64'd1);
    chk("t6_full", 64'(Full), 64'd0);
    chk("t6_strobes", {D_StartWrite, D_StartRead, U_WriteCompleted, U_ReadCompleted}, 64'd0);
    chk("t6_daddr", {D_Addr, D_WriteData}, 64'd0);
    chk("t6_rdata", 64'(U_ReadData), 64'd0);
    Rst = 1'b1;
    b_uwc = uwc_cnt; b_dsw = dsw_cnt; b_dsr = dsr_cnt; b_urc = urc_cnt;
    ds_wr_done(1, tc);
    repeat (8) @(negedge Clk);
    chk("t6_quiet", {32'(uwc_cnt - b_uwc), 32'(urc_cnt - b_urc)}, 64'd0);
    chk("t6_no_ds", {32'(dsw_cnt - b_dsw), 32'(dsr_cnt - b_dsr)}, 64'd0);
    chk("t6_empty_after", 64'(Empty), 64'd1);

    chk("end_wr_q", 64'(exp_wr_q.size()), 64'd0);
    chk("end_rd_q", 64'(exp_rd_q.size() + exp_rdata_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
